nickjhay_readout_seq: RTL and testbench

Parametrised readout/greeting sequencer for the processor's debug output path. On a rising edge of `readout_i` it walks the register file and streams every word onto the output bus in OUT_W-bit beats, MSB chunk first. On a rising edge of `sayhi_i` it emits the ASCII greeting "hi". It generalises the fixed 8-bit readout/sayhi path to arbitrary word width, register count and output width, and adds an optional checksum beat.

---
 rtl/nickjhay_readout_seq_if.sv | 31 +++
 rtl/nickjhay_readout_seq.sv | 169 ++++++++++++++++
 tb/tb_nickjhay_readout_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/nickjhay_readout_seq_if.sv
// Debug-output bus of the readout/greeting sequencer: register-file read port
// plus the beat stream. The sequencer is the master.
interface nickjhay_readout_seq_if #(
  parameter int WORD_W = 16,
  parameter int NREGS  = 8,
  parameter int OUT_W  = 8
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]     reg_rd_addr_o;
  logic [WORD_W-1:0] reg_rd_data_i;
  logic [OUT_W-1:0]  out_data_o;
  logic              out_valid_o;
  logic              busy_o;

  modport master (
    output reg_rd_addr_o,
    output out_data_o,
    output out_valid_o,
    output busy_o,
    input  reg_rd_data_i
  );

  modport slave (
    input  reg_rd_addr_o,
    input  out_data_o,
    input  out_valid_o,
    input  busy_o,
    output reg_rd_data_i
  );
endinterface

// File: rtl/nickjhay_readout_seq.sv
// Readout/greeting sequencer: dumps the register file MSB-chunk first, or says "hi".
// Optional trailing XOR checksum beat enabled by defining READOUT_CHECKSUM_EN.
module nickjhay_readout_seq #(
  parameter int WORD_W = 16,
  parameter int NREGS  = 8,
  parameter int OUT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    readout_i,
  input  logic                    sayhi_i,
  nickjhay_readout_seq_if.master  bus
);
  localparam int BEATS = WORD_W / OUT_W;
  localparam int AW    = $clog2(NREGS);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_HI0,
    S_HI1
`ifdef READOUT_CHECKSUM_EN
    , S_CSUM
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      r_q, r_d;
  logic [BW-1:0]      b_q, b_d;
  logic [WORD_W-1:0]  sreg_q, sreg_d;
  logic               ro_q, ro_d;
  logic               hi_q, hi_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
`ifdef READOUT_CHECKSUM_EN
  logic [OUT_W-1:0]   csum_q, csum_d;
`endif

  logic               ro_edge, hi_edge;
  logic [WORD_W-1:0]  shifted;

  assign ro_edge = readout_i & ~ro_q;
  assign hi_edge = sayhi_i & ~hi_q;
  assign shifted = sreg_q << OUT_W;

  // Outputs are registered one step ahead: out_data_d is the beat the next state presents.
  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    b_d         = b_q;
    sreg_d      = sreg_q;
    ro_d        = readout_i;
    hi_d        = sayhi_i;
    out_data_d  = '0;
    out_valid_d = 1'b0;
`ifdef READOUT_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (ro_edge) begin
          state_d = S_FETCH;
          r_d     = '0;
`ifdef READOUT_CHECKSUM_EN
          csum_d  = '0;
`endif
        end else if (hi_edge) begin
          state_d     = S_HI0;
          out_data_d  = OUT_W'(8'h68);
          out_valid_d = 1'b1;
        end
      end

      S_FETCH: begin
        sreg_d      = bus.reg_rd_data_i;
        b_d         = '0;
        state_d     = S_SHIFT;
        out_data_d  = bus.reg_rd_data_i[WORD_W-1 -: OUT_W];
        out_valid_d = 1'b1;
      end

      S_SHIFT: begin
        sreg_d = shifted;
        b_d    = b_q + BW'(1);
`ifdef READOUT_CHECKSUM_EN
        csum_d = csum_q ^ sreg_q[WORD_W-1 -: OUT_W];
`endif
        if (b_q == BW'(BEATS - 1)) begin
          b_d = '0;
          if (r_q < AW'(NREGS - 1)) begin
            r_d     = r_q + AW'(1);
            state_d = S_FETCH;
          end else begin
            // Parking r at 0 keeps the read address quiet outside a dump.
            r_d = '0;
`ifdef READOUT_CHECKSUM_EN
            state_d     = S_CSUM;
            out_data_d  = csum_d;
            out_valid_d = 1'b1;
`else
            state_d     = S_IDLE;
`endif
          end
        end else begin
          out_data_d  = shifted[WORD_W-1 -: OUT_W];
          out_valid_d = 1'b1;
        end
      end

      S_HI0: begin
        state_d     = S_HI1;
        out_data_d  = OUT_W'(8'h69);
        out_valid_d = 1'b1;
      end

      S_HI1: state_d = S_IDLE;

`ifdef READOUT_CHECKSUM_EN
      S_CSUM: state_d = S_IDLE;
`endif

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      b_q         <= '0;
      sreg_q      <= '0;
      ro_q        <= 1'b0;
      hi_q        <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      b_q         <= b_d;
      sreg_q      <= sreg_d;
      ro_q        <= ro_d;
      hi_q        <= hi_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef READOUT_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.reg_rd_addr_o = r_q;
  assign bus.out_data_o    = out_data_q;
  assign bus.out_valid_o   = out_valid_q;
  assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_nickjhay_readout_seq.sv
// Directed bench for nickjhay_readout_seq (WORD_W=16, NREGS=4, OUT_W=8);
// expectations follow READOUT_CHECKSUM_EN when the bench is built with it.
module tb_nickjhay_readout_seq;
  logic clk = 1'b0;
  logic rst;
  logic readout_i;
  logic sayhi_i;

  always #5 clk = ~clk;

  nickjhay_readout_seq_if #(.WORD_W(16), .NREGS(4), .OUT_W(8)) bus ();

  nickjhay_readout_seq #(.WORD_W(16), .NREGS(4), .OUT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .readout_i (readout_i),
    .sayhi_i   (sayhi_i),
    .bus       (bus)
  );

  logic [15:0] regs [4] = '{16'h1234, 16'hABCD, 16'h0001, 16'hFF00};
  assign bus.reg_rd_data_i = regs[bus.reg_rd_addr_o];

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor: beats seen, valid pattern over busy cycles, idle-data and address observations.
  logic [7:0]  beats [$];
  int          busy_len;
  logic [31:0] vpat;
  int          zero_viol;
  int          max_addr;

  always @(negedge clk) begin
    if (bus.busy_o) begin
      busy_len = busy_len + 1;
      vpat     = (vpat << 1) | 32'(bus.out_valid_o);
    end
    if (bus.out_valid_o) beats.push_back(bus.out_data_o);
    if (!bus.out_valid_o && bus.out_data_o != 8'h00) zero_viol = zero_viol + 1;
    if (int'(bus.reg_rd_addr_o) > max_addr) max_addr = int'(bus.reg_rd_addr_o);
  end

`ifdef READOUT_CHECKSUM_EN
  logic [7:0]  exp_dump [$] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00, 8'hBE};
  localparam int          DUMP_LEN = 13;
  localparam logic [31:0] DUMP_PAT = 32'h0DB7;
`else
  logic [7:0]  exp_dump [$] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00};
  localparam int          DUMP_LEN = 12;
  localparam logic [31:0] DUMP_PAT = 32'h06DB;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and checks happen 1 time unit after the falling edge, after the monitor.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    beats.delete();
    busy_len  = 0;
    vpat      = 0;
    zero_viol = 0;
    max_addr  = 0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (bus.busy_o && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check({tag, "_timeout"}, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic check_beats(input string tag, input logic [7:0] exp [$]);
    check({tag, "_nbeats"}, 32'(beats.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < beats.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(exp[i]));
  endtask

  task automatic check_dump(input string tag);
    check_beats(tag, exp_dump);
    check({tag, "_busy_len"}, 32'(busy_len), 32'(DUMP_LEN));
    check({tag, "_valid_pat"}, vpat, DUMP_PAT);
    check({tag, "_idle_data"}, 32'(zero_viol), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_hi [$];
    int c;
    exp_hi = '{8'h68, 8'h69};

    rst = 1'b1; readout_i = 1'b0; sayhi_i = 1'b0;
    clear_mon();
    tick(2);
    check("rst_addr",  32'(bus.reg_rd_addr_o), 32'd0);
    check("rst_data",  32'(bus.out_data_o),    32'd0);
    check("rst_valid", 32'(bus.out_valid_o),   32'd0);
    check("rst_busy",  32'(bus.busy_o),        32'd0);
    rst = 1'b0;
    tick(2);
    check("post_rst_busy", 32'(bus.busy_o), 32'd0);

    // Single readout pulse.
    clear_mon();
    readout_i = 1'b1;
    tick(1);
    readout_i = 1'b0;
    check("ro_first_addr", 32'(bus.reg_rd_addr_o), 32'd0);
    wait_idle("ro");
    tick(3);
    check_dump("ro");

    // Single sayhi pulse.
    clear_mon();
    sayhi_i = 1'b1;
    tick(1);
    sayhi_i = 1'b0;
    wait_idle("hi");
    tick(2);
    check_beats("hi", exp_hi);
    check("hi_busy_len",  32'(busy_len), 32'd2);
    check("hi_valid_pat", vpat,          32'h3);
    check("hi_addr_max",  32'(max_addr), 32'd0);

    // Both rise together: readout wins, greeting discarded.
    clear_mon();
    readout_i = 1'b1; sayhi_i = 1'b1;
    tick(1);
    readout_i = 1'b0; sayhi_i = 1'b0;
    wait_idle("both");
    tick(4);
    check_dump("both");

    // readout held through the dump, sayhi pulsed mid-dump: nothing extra, no restart.
    clear_mon();
    readout_i = 1'b1;
    tick(3);
    sayhi_i = 1'b1;
    tick(1);
    sayhi_i = 1'b0;
    wait_idle("hold");
    tick(6);
    check("hold_no_restart", 32'(bus.busy_o), 32'd0);
    check_dump("hold");
    readout_i = 1'b0;
    tick(2);

    // Back-to-back: a sayhi edge right after a readout is accepted once idle.
    clear_mon();
    sayhi_i = 1'b1;
    tick(1);
    check("b2b_busy", 32'(bus.busy_o), 32'd1);
    sayhi_i = 1'b0;
    wait_idle("b2b");
    check_beats("b2b", exp_hi);

    // Reset after the 3rd beat with readout held high.
    clear_mon();
    readout_i = 1'b1;
    c = 0;
    while (beats.size() < 3 && c < 100) begin
      tick(1);
      c++;
    end
    check("rst3_beats_seen", 32'(beats.size()), 32'd3);
    rst = 1'b1;
    #1;
    check("rst3_addr",  32'(bus.reg_rd_addr_o), 32'd0);
    check("rst3_data",  32'(bus.out_data_o),    32'd0);
    check("rst3_valid", 32'(bus.out_valid_o),   32'd0);
    check("rst3_busy",  32'(bus.busy_o),        32'd0);
    tick(2);
    check("rst3_no_beats", 32'(beats.size()), 32'd3);
    clear_mon();
    rst = 1'b0;
    tick(1);
    check("rst3_restart_busy", 32'(bus.busy_o), 32'd1);
    wait_idle("rst3");
    tick(2);
    check_dump("rst3");
    readout_i = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
